// File: rtl/sha3_seq_pkg.sv
// Shared constants, state encoding and core-bus request helpers for the SHA-3 sequencer.
package sha3_seq_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h09;
   localparam logic [7:0] ADDR_BLOCK  = 8'h40;
   localparam logic [7:0] ADDR_DIGEST = 8'h80;

   localparam int CTRL_INIT  = 0;
   localparam int CTRL_NEXT  = 1;
   localparam int STAT_READY = 0;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_CMD     = 4'd2,
      ST_GAP     = 4'd3,
      ST_POLL_RQ = 4'd4,
      ST_POLL_CK = 4'd5,
      ST_RD_RQ   = 4'd6,
      ST_RD_CK   = 4'd7,
      ST_OUT     = 4'd8
   } state_e;

   typedef struct packed {
      logic        cs;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } core_req_t;

   localparam core_req_t REQ_IDLE = '0;

   function automatic core_req_t core_wr(input logic [7:0] addr, input logic [31:0] data);
      core_req_t r;
      r.cs    = 1'b1;
      r.we    = 1'b1;
      r.addr  = addr;
      r.wdata = data;
      return r;
   endfunction

   function automatic core_req_t core_rd(input logic [7:0] addr);
      core_req_t r;
      r.cs    = 1'b1;
      r.we    = 1'b0;
      r.addr  = addr;
      r.wdata = 32'h0;
      return r;
   endfunction

endpackage

// File: rtl/sha3_seq_ctrl_if.sv
// Bundles the message stream, digest stream, core register bus and status flags.
interface sha3_seq_ctrl_if;

   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_first;
   logic        s_last;

   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   logic        core_cs;
   logic        core_we;
   logic [7:0]  core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;

   logic        busy;
   logic        err;

   modport slave (
      input  s_valid, s_data, s_first, s_last, m_ready, core_rdata,
      output s_ready, m_valid, m_data, m_last,
      output core_cs, core_we, core_addr, core_wdata, busy, err
   );

   modport master (
      output s_valid, s_data, s_first, s_last, m_ready, core_rdata,
      input  s_ready, m_valid, m_data, m_last,
      input  core_cs, core_we, core_addr, core_wdata, busy, err
   );

endinterface

// File: rtl/sha3_seq_ctrl.sv
// Sequences message blocks into an external SHA-3 core and streams the digest back out.
// Optional poll timeout enabled by defining SHA3_SEQ_TIMEOUT_EN.
module sha3_seq_ctrl
   import sha3_seq_pkg::*;
#(
   parameter int BLOCK_WORDS  = 34,
   parameter int DIGEST_WORDS = 8,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   sha3_seq_ctrl_if.slave  bus
);

   localparam int WCW = $clog2(BLOCK_WORDS > 1 ? BLOCK_WORDS : 2);
   localparam int KW  = $clog2(DIGEST_WORDS > 1 ? DIGEST_WORDS : 2);

   localparam logic [3:0] S_IDLE    = ST_IDLE;
   localparam logic [3:0] S_LOAD    = ST_LOAD;
   localparam logic [3:0] S_CMD     = ST_CMD;
   localparam logic [3:0] S_GAP     = ST_GAP;
   localparam logic [3:0] S_POLL_RQ = ST_POLL_RQ;
   localparam logic [3:0] S_POLL_CK = ST_POLL_CK;
   localparam logic [3:0] S_RD_RQ   = ST_RD_RQ;
   localparam logic [3:0] S_RD_CK   = ST_RD_CK;
   localparam logic [3:0] S_OUT     = ST_OUT;

   logic [3:0]     state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [KW-1:0]  k_q, k_d;
   logic [1:0]     gap_q, gap_d;
   logic           first_q, first_d;
   logic           last_q, last_d;
   core_req_t      req_q, req_d;
   logic           m_valid_q, m_valid_d;
   logic [31:0]    m_data_q, m_data_d;
   logic           m_last_q, m_last_d;
   logic [31:0]    ctrl_word;
   logic           s_ready;
   logic           accept;
   logic           timeout_hit;

   // Blocks the stream while reset is held so nothing is accepted mid-reset.
   assign s_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !rst;
   assign accept  = bus.s_valid && s_ready;

   always_comb begin
      ctrl_word            = 32'h0;
      ctrl_word[CTRL_INIT] = first_q;
      ctrl_word[CTRL_NEXT] = ~first_q;
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      k_d       = k_q;
      gap_d     = gap_q;
      first_d   = first_q;
      last_d    = last_q;
      req_d     = REQ_IDLE;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               req_d = core_wr(ADDR_BLOCK + 8'(wcnt_q), bus.s_data);
               if (wcnt_q == '0) first_d = bus.s_first;
               if (wcnt_q == WCW'(BLOCK_WORDS - 1)) begin
                  last_d  = bus.s_last;
                  wcnt_d  = '0;
                  state_d = S_CMD;
               end else begin
                  wcnt_d  = wcnt_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_CMD: begin
            req_d   = core_wr(ADDR_CTRL, ctrl_word);
            gap_d   = 2'd0;
            state_d = S_GAP;
         end
         // Control write occupies the first GAP cycle; two idle bus cycles follow.
         S_GAP: begin
            if (gap_q == 2'd2) begin
               req_d   = core_rd(ADDR_STATUS);
               state_d = S_POLL_RQ;
            end else begin
               gap_d = gap_q + 2'd1;
            end
         end
         S_POLL_RQ: state_d = S_POLL_CK;
         S_POLL_CK: begin
            if (bus.core_rdata[STAT_READY]) begin
               if (last_q) begin
                  req_d   = core_rd(ADDR_DIGEST + 8'(k_q));
                  state_d = S_RD_RQ;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (timeout_hit) begin
               state_d = S_IDLE;
            end else begin
               req_d   = core_rd(ADDR_STATUS);
               state_d = S_POLL_RQ;
            end
         end
         S_RD_RQ: state_d = S_RD_CK;
         S_RD_CK: begin
            m_data_d  = bus.core_rdata;
            m_valid_d = 1'b1;
            m_last_d  = (k_q == KW'(DIGEST_WORDS - 1));
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (bus.m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (k_q == KW'(DIGEST_WORDS - 1)) begin
                  k_d     = '0;
                  state_d = S_IDLE;
               end else begin
                  k_d     = k_q + 1'b1;
                  req_d   = core_rd(ADDR_DIGEST + 8'(k_q) + 8'd1);
                  state_d = S_RD_RQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         k_q       <= '0;
         gap_q     <= 2'd0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         req_q     <= REQ_IDLE;
         m_valid_q <= 1'b0;
         m_data_q  <= 32'h0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         k_q       <= k_d;
         gap_q     <= gap_d;
         first_q   <= first_d;
         last_q    <= last_d;
         req_q     <= req_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

`ifdef SHA3_SEQ_TIMEOUT_EN
   localparam int PCW = $clog2(POLL_TIMEOUT + 1);

   logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
   logic           err_q, err_d;

   always_comb begin
      poll_cnt_d = poll_cnt_q;
      if (state_q == S_CMD) poll_cnt_d = '0;
      else if (state_q == S_POLL_RQ) poll_cnt_d = poll_cnt_q + 1'b1;
   end

   assign timeout_hit = (poll_cnt_q == PCW'(POLL_TIMEOUT));
   assign err_d       = (state_q == S_POLL_CK) && !bus.core_rdata[STAT_READY] && timeout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         poll_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         poll_cnt_q <= poll_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   wire unused_poll_timeout = (POLL_TIMEOUT > 0);

   assign timeout_hit = 1'b0;
   assign bus.err     = 1'b0;
`endif

   assign bus.s_ready    = s_ready;
   assign bus.m_valid    = m_valid_q;
   assign bus.m_data     = m_data_q;
   assign bus.m_last     = m_last_q;
   assign bus.core_cs    = req_q.cs;
   assign bus.core_we    = req_q.we;
   assign bus.core_addr  = req_q.addr;
   assign bus.core_wdata = req_q.wdata;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
// Directed bench for sha3_seq_ctrl with a behavioural core model on the register bus.
`timescale 1ns/1ps
module tb_sha3_seq_ctrl;
   import sha3_seq_pkg::*;

   localparam int BW = 34;
   localparam int DW = 8;
`ifdef SHA3_SEQ_TIMEOUT_EN
   localparam int PT        = 16;
   localparam int SLOW_HOLD = 10;
`else
   localparam int PT        = 1024;
   localparam int SLOW_HOLD = 50;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha3_seq_ctrl_if ifc ();

   sha3_seq_ctrl #(
      .BLOCK_WORDS  (BW),
      .DIGEST_WORDS (DW),
      .POLL_TIMEOUT (PT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Core model: status returns ready after hold_cfg not-ready polls per command.
   int hold_cfg;
   int polls_since_cmd = 0;
   int ready_cnt = 0;
   always @(posedge clk) begin
      if (ifc.core_cs && ifc.core_we && ifc.core_addr == ADDR_CTRL) begin
         polls_since_cmd <= 0;
      end else if (ifc.core_cs && !ifc.core_we) begin
         if (ifc.core_addr == ADDR_STATUS) begin
            polls_since_cmd <= polls_since_cmd + 1;
            if (polls_since_cmd >= hold_cfg) begin
               ifc.core_rdata <= 32'h1;
               ready_cnt      <= ready_cnt + 1;
            end else begin
               ifc.core_rdata <= 32'h0;
            end
         end else begin
            ifc.core_rdata <= 32'hD160_0000 | {24'h0, ifc.core_addr};
         end
      end
   end

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          ctrl_at;
      int          ready_at;
   } wr_t;

   wr_t         blk_q[$];
   logic [31:0] ctrl_q[$];
   logic [7:0]  dig_addr_q[$];
   int          dig_ctrl_at_q[$];
   int          status_rd = 0;
   int          idle_gap = -1;
   int          gap_run = 0;
   int          err_cnt = 0;
   int          mvalid_cnt = 0;
   bit          in_gap = 1'b0;

   always @(negedge clk) begin
      if (ifc.err) err_cnt++;
      if (ifc.m_valid) mvalid_cnt++;
      if (ifc.core_cs && ifc.core_we && ifc.core_addr == ADDR_CTRL) begin
         ctrl_q.push_back(ifc.core_wdata);
         in_gap  = 1'b1;
         gap_run = 0;
      end else if (ifc.core_cs && ifc.core_we) begin
         blk_q.push_back('{ifc.core_addr, ifc.core_wdata, ctrl_q.size(), ready_cnt});
      end else if (ifc.core_cs) begin
         if (ifc.core_addr == ADDR_STATUS) begin
            status_rd++;
            if (in_gap) begin
               idle_gap = gap_run;
               in_gap   = 1'b0;
            end
         end else begin
            dig_addr_q.push_back(ifc.core_addr);
            dig_ctrl_at_q.push_back(ctrl_q.size());
         end
      end else if (in_gap) begin
         gap_run++;
      end
   end

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic f, input logic l);
      int t;
      t = 0;
      ifc.s_valid = 1'b1;
      ifc.s_data  = d;
      ifc.s_first = f;
      ifc.s_last  = l;
      while (ifc.s_ready !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("s_ready_wait", {31'h0, ifc.s_ready}, 32'h1);
      @(negedge clk);
      ifc.s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [31:0] base, input logic f0, input logic fo,
                             input logic ll, input logic lo);
      for (int i = 0; i < BW; i++)
         send_word(base + 32'(i), (i == 0) ? f0 : fo, (i == BW - 1) ? ll : lo);
   endtask

   task automatic recv_digest(input int stall_k);
      for (int k = 0; k < DW; k++) begin
         int          t;
         logic [31:0] d0;
         int          rd0;
         bit          stable;
         t = 0;
         while (ifc.m_valid !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
         end
         check($sformatf("m_data[%0d]", k), ifc.m_data, 32'hD160_0080 + 32'(k));
         check($sformatf("m_last[%0d]", k), {31'h0, ifc.m_last}, (k == DW - 1) ? 32'h1 : 32'h0);
         if (k == stall_k) begin
            d0     = ifc.m_data;
            rd0    = dig_addr_q.size();
            stable = 1'b1;
            repeat (10) begin
               @(negedge clk);
               if (ifc.m_valid !== 1'b1 || ifc.m_data !== d0) stable = 1'b0;
            end
            check("stall_stable", {31'h0, stable}, 32'h1);
            check("stall_no_reads", 32'(dig_addr_q.size()), 32'(rd0));
         end
         ifc.m_ready = 1'b1;
         @(negedge clk);
         ifc.m_ready = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (ifc.busy !== 1'b0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("idle_busy", {31'h0, ifc.busy}, 32'h0);
   endtask

   task automatic check_digest_reads(input string tag, input int base);
      int good;
      good = 0;
      for (int k = 0; k < DW; k++)
         if (base + k < dig_addr_q.size() && dig_addr_q[base + k] == ADDR_DIGEST + 8'(k)) good++;
      check({tag, "_dig_cnt"}, 32'(dig_addr_q.size() - base), 32'(DW));
      check({tag, "_dig_addr"}, 32'(good), 32'(DW));
   endtask

   initial begin : stim
      int b_blk, b_ctrl, b_st, b_dig, b_rdy, b_err, b_mv, good;
      ifc.s_valid = 1'b0;
      ifc.s_data  = 32'h0;
      ifc.s_first = 1'b0;
      ifc.s_last  = 1'b0;
      ifc.m_ready = 1'b0;
      hold_cfg    = 3;
      rst         = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_s_ready", {31'h0, ifc.s_ready}, 32'h0);
      check("rst_busy", {31'h0, ifc.busy}, 32'h0);
      check("rst_m_valid", {31'h0, ifc.m_valid}, 32'h0);
      check("rst_core_cs", {31'h0, ifc.core_cs}, 32'h0);
      check("rst_err", {31'h0, ifc.err}, 32'h0);
      check("rst_m_data", ifc.m_data, 32'h0);
      rst = 1'b0;
      #1;
      check("rel_s_ready", {31'h0, ifc.s_ready}, 32'h1);
      @(negedge clk);

      // single first+last block, data = word index
      b_blk = blk_q.size(); b_ctrl = ctrl_q.size(); b_st = status_rd; b_dig = dig_addr_q.size();
      hold_cfg = 3;
      send_block(32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      recv_digest(-1);
      wait_idle();
      good = 0;
      for (int i = 0; i < BW; i++)
         if (b_blk + i < blk_q.size() && blk_q[b_blk + i].addr == ADDR_BLOCK + 8'(i)
             && blk_q[b_blk + i].data == 32'(i)) good++;
      check("t1_blk_cnt", 32'(blk_q.size() - b_blk), 32'(BW));
      check("t1_blk_match", 32'(good), 32'(BW));
      check("t1_ctrl_cnt", 32'(ctrl_q.size() - b_ctrl), 32'h1);
      check("t1_ctrl_data", ctrl_q[b_ctrl], 32'h1);
      check("t1_idle_gap", 32'(idle_gap), 32'h2);
      check("t1_status_rd", 32'(status_rd - b_st), 32'h4);
      check_digest_reads("t1", b_dig);

      // two blocks; first/last toggled on the words where they are ignored
      b_blk = blk_q.size(); b_ctrl = ctrl_q.size(); b_dig = dig_addr_q.size(); b_rdy = ready_cnt;
      hold_cfg = 0;
      send_block(32'd100, 1'b1, 1'b0, 1'b0, 1'b1);
      send_block(32'd200, 1'b0, 1'b1, 1'b1, 1'b0);
      recv_digest(-1);
      wait_idle();
      check("t2_blk_cnt", 32'(blk_q.size() - b_blk), 32'(2 * BW));
      check("t2_ctrl_cnt", 32'(ctrl_q.size() - b_ctrl), 32'h2);
      check("t2_ctrl0", ctrl_q[b_ctrl], 32'h1);
      check("t2_ctrl1", ctrl_q[b_ctrl + 1], 32'h2);
      check("t2_w33_before_ready", 32'(blk_q[b_blk + BW - 1].ready_at - b_rdy), 32'h0);
      check("t2_b2w0_after_ready", 32'(blk_q[b_blk + BW].ready_at - b_rdy), 32'h1);
      check("t2_b2w0_addr", {24'h0, blk_q[b_blk + BW].addr}, 32'h40);
      check("t2_b2w0_data", blk_q[b_blk + BW].data, 32'd200);
      good = 0;
      for (int k = b_dig; k < dig_ctrl_at_q.size(); k++)
         if (dig_ctrl_at_q[k] == b_ctrl + 2) good++;
      check("t2_dig_after_2nd", 32'(good), 32'(DW));
      check_digest_reads("t2", b_dig);

      // slow core: SLOW_HOLD not-ready polls
      b_st = status_rd; b_dig = dig_addr_q.size();
      hold_cfg = SLOW_HOLD;
      send_block(32'd300, 1'b1, 1'b1, 1'b1, 1'b1);
      recv_digest(-1);
      wait_idle();
      check("t3_status_rd", 32'(status_rd - b_st), 32'(SLOW_HOLD + 1));
      check_digest_reads("t3", b_dig);

      // downstream back-pressure on digest word 3
      b_dig = dig_addr_q.size();
      hold_cfg = 1;
      send_block(32'd400, 1'b1, 1'b1, 1'b1, 1'b1);
      recv_digest(3);
      wait_idle();
      check_digest_reads("t4", b_dig);

`ifdef SHA3_SEQ_TIMEOUT_EN
      // core never ready: must abort after PT polls
      b_st = status_rd; b_dig = dig_addr_q.size(); b_err = err_cnt; b_mv = mvalid_cnt;
      hold_cfg = 1000000;
      send_block(32'd450, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_idle();
      repeat (5) @(negedge clk);
      check("t5_err_pulses", 32'(err_cnt - b_err), 32'h1);
      check("t5_status_rd", 32'(status_rd - b_st), 32'(PT));
      check("t5_busy", {31'h0, ifc.busy}, 32'h0);
      check("t5_m_valid_seen", 32'(mvalid_cnt - b_mv), 32'h0);
      check("t5_dig_reads", 32'(dig_addr_q.size() - b_dig), 32'h0);
`endif

      // reset in the middle of a block
      hold_cfg = 2;
      for (int i = 0; i < 20; i++)
         send_word(32'd500 + 32'(i), 1'b1, 1'b1);
      ifc.s_valid = 1'b1;
      ifc.s_data  = 32'd520;
      rst = 1'b1;
      #1;
      check("t6_cs_we_addr", {22'h0, ifc.core_cs, ifc.core_we, ifc.core_addr}, 32'h0);
      check("t6_wdata", ifc.core_wdata, 32'h0);
      check("t6_m_out", {30'h0, ifc.m_valid, ifc.m_last}, 32'h0);
      check("t6_m_data", ifc.m_data, 32'h0);
      check("t6_busy_err", {30'h0, ifc.busy, ifc.err}, 32'h0);
      check("t6_s_ready", {31'h0, ifc.s_ready}, 32'h0);
      @(negedge clk);
      ifc.s_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      b_blk = blk_q.size(); b_ctrl = ctrl_q.size(); b_dig = dig_addr_q.size();
      send_block(32'd600, 1'b1, 1'b1, 1'b1, 1'b1);
      recv_digest(-1);
      wait_idle();
      check("t6_blk_cnt", 32'(blk_q.size() - b_blk), 32'(BW));
      check("t6_first_addr", {24'h0, blk_q[b_blk].addr}, 32'h40);
      check("t6_first_data", blk_q[b_blk].data, 32'd600);
      check("t6_ctrl_data", ctrl_q[b_ctrl], 32'h1);
      check_digest_reads("t6", b_dig);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sha3_seq_ctrl.md
SHA3_SEQ_CTRL -- requirements
Module: sha3_seq_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 34, meaning 32-bit words per absorbed block (rate 1088 bits).
REQ-002 SHALL have parameter DIGEST_WORDS, default 8, meaning 32-bit digest words read out per message.
REQ-003 SHALL have parameter POLL_TIMEOUT, default 1024, meaning the maximum status polls per command before abort.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: clock  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-005 Ports: s_valid  in  1  input word valid; s_ready  out  1  input word accepted; s_data  in  32  message word; s_first  in  1  block is first of message; s_last  in  1  block is last of message.
REQ-006 Ports: m_valid  out  1  digest word valid; m_ready  in  1  downstream accepts; m_data  out  32  digest word; m_last  out  1  final digest word.
REQ-007 Ports: core_cs  out  1  core select; core_we  out  1  core write; core_addr  out  8  core register address; core_wdata  out  32  core write data; core_rdata  in  32  core read data (valid 1 cycle after a read).
REQ-008 Ports: busy  out  1  state != IDLE; err  out  1  one-cycle timeout pulse.

Function
REQ-009 States SHALL be IDLE, LOAD, CMD, GAP, POLL_RQ, POLL_CK, RD_RQ, RD_CK, OUT.
REQ-010 IDLE/LOAD: s_ready=1; word accepted (s_valid&s_ready) at cycle N SHALL appear as a registered write at cycle N+1: core_cs=1, core_we=1, core_addr=ADDR_BLOCK+wcnt, core_wdata=s_data.
REQ-011 wcnt SHALL start at 0, increment per accepted word, and wrap to 0 after BLOCK_WORDS-1.
REQ-012 s_first SHALL be sampled on word 0 only; s_last SHALL be sampled on word BLOCK_WORDS-1 only; ignored otherwise.
REQ-013 After word BLOCK_WORDS-1: s_ready=0; CMD SHALL write ADDR_CTRL with bit CTRL_INIT=first, bit CTRL_NEXT=~first, for one cycle.
REQ-014 GAP SHALL idle the core bus for 2 cycles before the first poll.
REQ-015 POLL_RQ SHALL read ADDR_STATUS (cs=1, we=0); POLL_CK SHALL sample core_rdata[STAT_READY]; 0 -> POLL_RQ; 1 -> RD_RQ if last, else IDLE.
REQ-016 RD_RQ SHALL read ADDR_DIGEST+k; RD_CK SHALL register core_rdata into m_data and enter OUT with m_valid=1.
REQ-017 OUT: m_valid, m_data, m_last SHALL hold stable until m_ready; on handshake k increments; m_last=1 iff k=DIGEST_WORDS-1; after final handshake -> IDLE.
REQ-018 core_cs SHALL be 0 in every cycle without a bus access; no overlapping accesses.
REQ-019 No input word SHALL be accepted outside IDLE/LOAD; s_valid held during a command SHALL stall.

Reset
REQ-020 Reset SHALL force IDLE, wcnt=0, k=0, poll counter=0, and every output to 0 except s_ready=1 once deasserted.
REQ-021 Reset mid-operation SHALL abandon the block; no pending core access or digest word SHALL be issued afterwards.

Configuration
REQ-022 Macro SHA3_SEQ_TIMEOUT_EN defined: poll counter increments per POLL_RQ; reaching POLL_TIMEOUT SHALL pulse err for 1 cycle and go to IDLE with no digest output.
REQ-023 Macro undefined: polling SHALL be unbounded, err tied 0, no counter logic.

Structure
REQ-024 Package sha3_seq_pkg SHALL hold ADDR_CTRL=8'h08, ADDR_STATUS=8'h09, ADDR_BLOCK=8'h40, ADDR_DIGEST=8'h80, CTRL_INIT=0, CTRL_NEXT=1, STAT_READY=0, and the state enum.
REQ-025 Single module, no sub-module; the core is instantiated outside.

Verification
REQ-026 One block, s_first=1, s_last=1, data=i: 34 writes to 8'h40..8'h61 -> CTRL write 32'h1 -> poll until ready -> 8 reads 8'h80..8'h87 -> m_last on 8th word.
REQ-027 Two blocks (first, then last): CTRL 32'h1, then 32'h2; digest read only after 2nd block.
REQ-028 Model holds STAT_READY=0 for 50 polls -> exactly 50+1 status reads, then digest.
REQ-029 m_ready low for 10 cycles on word 3 -> m_data/m_valid stable, no extra core reads.
REQ-030 SHA3_SEQ_TIMEOUT_EN, POLL_TIMEOUT=16, ready never set -> err pulses once after 16 polls, busy=0, m_valid never 1.
REQ-031 Reset asserted at word 20 of block -> next cycle all outputs 0, new block restarts at address 8'h40.
